sseg_scan_ctrl: RTL and testbench
=================================

// Module: sseg_scan_ctrl
// PURPOSE
//  Parametrised N-digit multiplexed seven-segment driver. It scans NUM_DIGITS hex digits,
//  with per-digit decimal points, tear-free frame-synchronous value loading, leading-zero
//  blanking and 16-level PWM brightness. It sits between user logic and the board anode and
//  segment pins, and replaces the fixed 4-digit free-running scanner.
// PARAMETERS
//  NUM_DIGITS  4  digits scanned (2..8); digit 0 = rightmost / least significant
//  SUB_DIV     1563  clk cycles per PWM subslot (>=1); one digit slot = 16*SUB_DIV cycles
//  ACTIVE_LOW  1  1: anodes and segments driven low-active; 0: high-active
// PORTS
//  clk         in   1              system clock
//  rst         in   1              synchronous, active-high reset
//  value       in   4*NUM_DIGITS   hex nibbles; value[4i+3:4i] = digit i
//  dp          in   NUM_DIGITS     decimal point enable per digit
//  load        in   1              request to capture value/dp into the shadow register
//  lz_blank    in   1              1: suppress leading zeros
//  brightness  in   4              duty level 0..15 (0 = 1/16 on, 15 = always on)
//  sseg_an     out  NUM_DIGITS     anode enables (polarity per ACTIVE_LOW)
//  sseg_sig    out  8              {dp,g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
//  frame_tick  out  1              1-cycle pulse at the start of each scan frame
// BEHAVIOUR
//  - Counters: div_cnt 0..SUB_DIV-1; sub_cnt 0..15 increments when div_cnt wraps; sel
//    0..NUM_DIGITS-1 increments when sub_cnt wraps 15->0; sel wraps NUM_DIGITS-1 -> 0.
//  - Frame start is the cycle in which sel wraps to 0 (all counters = 0 next cycle).
//    frame_tick is registered and asserts for exactly 1 cycle, aligned with the first
//    output cycle of digit 0.
//  - load sets load_pending (sticky). At frame start with load_pending=1: value/dp sampled
//    that cycle -> shadow; load_pending cleared. load asserted in the same cycle as frame
//    start is captured in that frame start. The display never uses a mix of old and new
//    shadow within one frame.
//  - Leading-zero blank (lz_blank=1): digit i is blanked if all shadow nibbles j>=i are 0,
//    for i>=1. Digit 0 is never blanked. A blanked digit's dp still shows if dp[i]=1.
//    Evaluated combinationally from shadow and lz_blank; lz_blank is not frame-synchronised.
//  - PWM: the selected anode is on while sub_cnt <= brightness, and off otherwise.
//    brightness is sampled live.
//  - Decode: standard hex 0-F (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,
//    A=77,b=7C,C=39,d=5E,E=79,F=71, as active-high {g..a}); dp bit = dp[sel].
//  - Output timing: sseg_an, sseg_sig and frame_tick are registered, with 1 cycle of latency
//    from the counter state. Exactly one anode is active, or none (PWM off). Segments stay
//    valid during the PWM-off time.
//  - Polarity: ACTIVE_LOW=1 inverts both buses at the output register only.
//  - Reset: counters=0, sel=0, shadow=0, load_pending=0, frame_tick=0. All anodes and all
//    segments are inactive (sseg_an='1s, sseg_sig=8'hFF for ACTIVE_LOW=1). The first frame
//    starts on the first cycle after rst deasserts, with frame_tick=1 one cycle later.
//    Reset mid-frame aborts the scan immediately and discards a pending load.
// TESTING  (NUM_DIGITS=4, SUB_DIV=2, ACTIVE_LOW=1: slot = 32 cycles, frame = 128 cycles)
//  1. Reset hold and release:
//     - during rst: sseg_an=4'hF, sseg_sig=8'hFF;
//     - after release: frame_tick is high 1 cycle, then every 128 cycles.
//  2. Load 16'h1234 with dp=4'b0010, brightness=15. Required anodes: 4'b1110 for 32 cycles,
//     then 1101, 1011, 0111. Segments are ~8'h66 ('4'), ~8'hCF ('3'+dp), ~8'h5B, ~8'h06.
//  3. Pulse load mid-frame with a new value:
//     - the current frame still shows the old value;
//     - the new value appears from the next frame_tick;
//     - change value after load without re-loading: no effect.
//  4. Leading-zero blank: value=16'h0050, lz_blank=1. Digits 3 and 2 show sseg_sig=8'hFF,
//     digit 1 shows '5', digit 0 shows '0'. value=0: only digit 0 lit. lz_blank=0: all shown.
//  5. Brightness: brightness=0 -> each anode active 2 of 32 slot cycles;
//     brightness=7 -> 16 of 32; brightness=15 -> 32 of 32 (continuous).
//  6. Assert rst mid-slot of digit 2 with load pending:
//     - outputs go inactive the next cycle;
//     - after release the scan restarts at digit 0 with shadow=0 (pending load discarded).

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed N-digit hex seven-segment scanner with tear-free loading, leading-zero blanking and 16-level PWM.
// Latency: sseg_an/sseg_sig/frame_tick are registered, one cycle behind the scan counters.
// Backpressure: none; load is a sticky request honoured at the next frame boundary.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   value, dp   hex nibbles (digit i = value[4i+3:4i]) and per-digit decimal points
//   load        request to copy value/dp into the display shadow at the next frame start
//   lz_blank    suppress leading zero digits (digit 0 always shown), applied live
//   brightness  PWM duty 0..15 (anode on while sub_cnt <= brightness), applied live
//   sseg_an     anode enables; sseg_sig = {dp,g,f,e,d,c,b,a}; both inverted when ACTIVE_LOW
//   frame_tick  one-cycle pulse coincident with the first output cycle of digit 0
module sseg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SUB_DIV    = 1563,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   sseg_an,
    output logic [7:0]              sseg_sig,
    output logic                    frame_tick
);

    localparam int DIV_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int SEL_W = $clog2(NUM_DIGITS);

    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SUB_DIV - 1);
    localparam logic [SEL_W-1:0]      SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    // XOR masks that turn active-high internal values into pin polarity;
    // they double as the "everything off" reset value of the output flops.
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{(ACTIVE_LOW != 0)}};
    localparam logic [7:0]            SIG_OFF  = {8{(ACTIVE_LOW != 0)}};

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [3:0]              sub_cnt_q, sub_cnt_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    load_pending_q, load_pending_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   sseg_an_q, sseg_an_d;
    logic [7:0]              sseg_sig_q, sseg_sig_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    div_wrap;
    logic                    sub_wrap;
    logic                    frame_start;
    logic                    upper_zero;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              cur_nib;
    logic                    an_on;
    logic [NUM_DIGITS-1:0]   an_raw;
    logic [7:0]              sig_raw;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Scan counters and frame-synchronous shadow load.
    always_comb begin
        div_wrap    = (div_cnt_q == DIV_LAST);
        sub_wrap    = div_wrap && (sub_cnt_q == 4'hF);
        // Last cycle of the last digit: counters are all zero next cycle.
        frame_start = sub_wrap && (sel_q == SEL_LAST);

        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        sub_cnt_d = div_wrap ? sub_cnt_q + 4'd1 : sub_cnt_q;
        sel_d     = sel_q;
        if (sub_wrap) begin
            sel_d = frame_start ? '0 : sel_q + 1'b1;
        end

        // A load arriving in the frame-start cycle itself is honoured at once,
        // so the shadow only ever changes between frames.
        load_pending_d = load_pending_q | load;
        shadow_val_d   = shadow_val_q;
        shadow_dp_d    = shadow_dp_q;
        if (frame_start) begin
            load_pending_d = 1'b0;
            if (load_pending_q || load) begin
                shadow_val_d = value;
                shadow_dp_d  = dp;
            end
        end
    end

    // Leading-zero blanking, walking down from the most significant digit.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (shadow_val_q[4*i +: 4] == 4'h0);
            blank[i]   = lz_blank && upper_zero && (i != 0);
        end
    end

    // Output stage: decode the selected digit and apply PWM to its anode.
    always_comb begin
        cur_nib = shadow_val_q[{sel_q, 2'b00} +: 4];
        an_on   = (sub_cnt_q <= brightness);
        an_raw  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_raw[i] = an_on && (sel_q == SEL_W'(i));
        end
        // Segments are held during the PWM-off time; a blanked digit keeps its dp.
        sig_raw      = {shadow_dp_q[sel_q], blank[sel_q] ? 7'h00 : hex_to_seg(cur_nib)};
        sseg_an_d    = an_raw ^ AN_OFF;
        sseg_sig_d   = sig_raw ^ SIG_OFF;
        frame_tick_d = (div_cnt_q == '0) && (sub_cnt_q == 4'h0) && (sel_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q      <= '0;
            sub_cnt_q      <= '0;
            sel_q          <= '0;
            load_pending_q <= 1'b0;
            shadow_val_q   <= '0;
            shadow_dp_q    <= '0;
            sseg_an_q      <= AN_OFF;
            sseg_sig_q     <= SIG_OFF;
            frame_tick_q   <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            sub_cnt_q      <= sub_cnt_d;
            sel_q          <= sel_d;
            load_pending_q <= load_pending_d;
            shadow_val_q   <= shadow_val_d;
            shadow_dp_q    <= shadow_dp_d;
            sseg_an_q      <= sseg_an_d;
            sseg_sig_q     <= sseg_sig_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign sseg_an    = sseg_an_q;
    assign sseg_sig   = sseg_sig_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl (4 digits, SUB_DIV=2, active-low): 32-cycle slots, 128-cycle frames.
// Stimulus queues hand-computed per-frame segment/brightness expectations; a monitor checks each frame.
// A second monitor checks frame_tick spacing and the inactive outputs while reset is applied.
module tb_sseg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        lz_blank;
    logic [3:0]  brightness;
    logic [3:0]  sseg_an;
    logic [7:0]  sseg_sig;
    logic        frame_tick;

    sseg_scan_ctrl #(
        .NUM_DIGITS (4),
        .SUB_DIV    (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .sseg_an    (sseg_an),
        .sseg_sig   (sseg_sig),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected frame: segment bus per digit {d3,d2,d1,d0} as seen on the pins.
    typedef struct {
        int          frame;
        logic [31:0] sig;
        int          bright;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   frame_no = 0;

    task automatic push(input int f, input logic [31:0] s, input int b, input string n);
        exp_t e;
        e.frame  = f;
        e.sig    = s;
        e.bright = b;
        e.name   = n;
        exp_q.push_back(e);
    endtask

    // Checks one full frame starting at the negedge where frame_tick was seen.
    task automatic check_frame(input exp_t e);
        logic [3:0] want_an;
        logic [3:0] got_an_bad, want_an_bad;
        logic [7:0] got_sig_bad;
        int         an_bad, sig_bad, on_cnt, bad_c;
        for (int d = 0; d < 4; d++) begin
            an_bad = 0; sig_bad = 0; on_cnt = 0; bad_c = 0;
            got_an_bad = 4'h0; want_an_bad = 4'h0; got_sig_bad = 8'h00;
            for (int c = 0; c < 32; c++) begin
                if (!(d == 0 && c == 0)) @(negedge clk);
                want_an = (c / 2 <= e.bright) ? 4'(~(4'b0001 << d)) : 4'hF;
                if (sseg_an != 4'hF) on_cnt++;
                if (sseg_an != want_an) begin
                    if (an_bad == 0) begin
                        got_an_bad  = sseg_an;
                        want_an_bad = want_an;
                        bad_c       = c;
                    end
                    an_bad++;
                end
                if (sseg_sig != e.sig[8*d +: 8]) begin
                    if (sig_bad == 0) got_sig_bad = sseg_sig;
                    sig_bad++;
                end
            end
            checks++;
            if (an_bad != 0) begin
                errors++;
                $display("FAIL %s frame %0d digit %0d anodes: cycle %0d got %b want %b (on %0d of 32, want %0d)",
                         e.name, e.frame, d, bad_c, got_an_bad, want_an_bad, on_cnt, 2 * (e.bright + 1));
            end
            checks++;
            if (sig_bad != 0) begin
                errors++;
                $display("FAIL %s frame %0d digit %0d segments: got %h want %h (%0d bad cycles)",
                         e.name, e.frame, d, got_sig_bad, e.sig[8*d +: 8], sig_bad);
            end
        end
    endtask

    // Scoreboard monitor: on every frame_tick, pop and check the matching expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_tick) begin
                frame_no++;
                while (exp_q.size() > 0 && exp_q[0].frame < frame_no) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL %s frame %0d never checked: now at frame %0d", e.name, e.frame, frame_no);
                end
                if (exp_q.size() > 0 && exp_q[0].frame == frame_no) begin
                    e = exp_q.pop_front();
                    check_frame(e);
                end
            end
        end
    end

    // frame_tick spacing and reset-state monitor.
    initial begin
        int since     = 0;
        bit after_rst = 1'b0;
        bit prev_rst  = 1'b0;
        int want;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                checks++;
                if (sseg_an != 4'hF || sseg_sig != 8'hFF || frame_tick != 1'b0) begin
                    errors++;
                    $display("FAIL rst_outputs: got an=%b sig=%h tick=%b want an=1111 sig=ff tick=0",
                             sseg_an, sseg_sig, frame_tick);
                end
            end
            if (rst) begin
                since     = 0;
                after_rst = 1'b1;
            end else begin
                since++;
                if (frame_tick) begin
                    want = after_rst ? 2 : 128;
                    checks++;
                    if (since != want) begin
                        errors++;
                        $display("FAIL tick_spacing: got %0d cycles want %0d", since, want);
                    end
                    since     = 0;
                    after_rst = 1'b0;
                end
            end
            prev_rst = rst;
        end
    end

    // Waits for the next frame_tick (bounded) and returns its frame number.
    task automatic wait_tick(output int f);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (frame_tick) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: got no frame_tick in 300 cycles want one every 128");
        end
        @(negedge clk); #1;
        f = frame_no;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        cycles(1);
        load = 1'b0;
    endtask

    initial begin
        int f;
        rst = 1'b1; value = 16'h0; dp = 4'h0; load = 1'b0; lz_blank = 1'b0; brightness = 4'd15;
        push(1, {4{8'hC0}}, 15, "rst_frame");
        push(2, 32'hF9A4_3099, 15, "val_1234");
        cycles(4);
        rst = 1'b0; value = 16'h1234; dp = 4'b0010;
        pulse_load();
        wait_tick(f);
        if (f < 2) wait_tick(f);

        // Frame 2: load a new value mid-frame; current frame keeps the old one.
        cycles(40);
        value = 16'hABCD; dp = 4'b0001;
        push(f + 1, 32'h8883_C621, 15, "val_abcd");
        pulse_load();
        wait_tick(f);
        value = 16'hFFFF; dp = 4'hF;
        push(f + 1, 32'h8883_C621, 15, "no_reload");
        wait_tick(f);

        // Load asserted in the frame-start cycle itself, with leading-zero blanking.
        cycles(126);
        value = 16'h0050; dp = 4'h0; lz_blank = 1'b1;
        push(f + 1, 32'hFFFF_92C0, 15, "lz_0050");
        pulse_load();
        wait_tick(f);
        cycles(40);
        value = 16'h0000;
        push(f + 1, 32'hFFFF_FFC0, 15, "lz_zero");
        pulse_load();
        wait_tick(f);
        wait_tick(f);
        cycles(40);
        lz_blank = 1'b0;
        push(f + 1, {4{8'hC0}}, 15, "lz_off");
        wait_tick(f);

        // Brightness levels.
        wait_tick(f);
        cycles(40);
        brightness = 4'd0; value = 16'h9876; dp = 4'b1000;
        push(f + 1, 32'h1080_F882, 0, "bright0");
        pulse_load();
        wait_tick(f);
        wait_tick(f);
        cycles(40);
        brightness = 4'd7;
        push(f + 1, 32'h1080_F882, 7, "bright7");
        wait_tick(f);

        // Reset in the middle of digit 2 with a load pending.
        wait_tick(f);
        cycles(5);
        value = 16'h5555; dp = 4'hF;
        pulse_load();
        cycles(69);
        rst = 1'b1;
        push(f + 1, {4{8'hC0}}, 7, "post_rst");
        cycles(3);
        rst = 1'b0;
        wait_tick(f);
        cycles(135);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d unchecked want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
